datapath_sequencer: RTL and testbench

Micro-program sequencer that sits directly upstream of `Datapath` and drives its `wr`, `ALUControl`, `addr1`, `addr2`, `addr3` inputs while consuming its `Zero` flag. It holds a 16-word loadable program memory and runs it on a `start` pulse. Each instruction is fetched and then executed as an ALU write-back, a branch-on-Zero, a jump or a halt. A step watchdog aborts runaway programs.

---
 rtl/datapath_sequencer.sv | 139 +++++++++++++
 tb/tb_datapath_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Micro-program sequencer driving a Datapath: 16-word loadable program memory,
// FETCH/EXEC instruction cycle, branch-on-Zero, jumps, halt and a step watchdog.
module datapath_sequencer #(
  parameter int MAX_STEPS = 255,
  parameter int STEP_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [3:0]  load_addr,
  input  logic [13:0] load_data,
  input  logic        start,
  input  logic        Zero,
  output logic        wr,
  output logic [2:0]  ALUControl,
  output logic [1:0]  addr1,
  output logic [1:0]  addr2,
  output logic [1:0]  addr3,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] K_ALU  = 2'b00;
  localparam logic [1:0] K_BZ   = 2'b01;
  localparam logic [1:0] K_JMP  = 2'b10;
  localparam logic [1:0] K_HALT = 2'b11;

  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  logic [13:0]       mem [16];
  state_t            state_q, state_d;
  logic [3:0]        pc_q, pc_d;
  logic [STEP_W-1:0] steps_q, steps_d, steps_inc;
  logic [13:0]       inst_q, inst_d;
  logic              err_q, err_d;
  logic [1:0]        kind;
  logic [3:0]        target;
  logic              unused_inst_bit;

  // Program memory is deliberately not reset so it survives resets and runs.
  always_ff @(posedge clk) begin
    if (load_en && (state_q == IDLE)) begin
      mem[load_addr] <= load_data;
    end
  end

  assign kind            = inst_q[13:12];
  assign target          = inst_q[3:0];
  assign steps_inc       = steps_q + STEP_W'(1);
  assign unused_inst_bit = inst_q[4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= 4'd0;
      steps_q <= '0;
      inst_q  <= 14'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      steps_q <= steps_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    steps_d = steps_q;
    inst_d  = inst_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = 4'd0;
          steps_d = '0;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        inst_d  = mem[pc_q];
        state_d = EXEC;
      end
      EXEC: begin
        if (kind == K_HALT) begin
          state_d = DONE;
        end else begin
          steps_d = steps_inc;
          case (kind)
            K_ALU:   pc_d = pc_q + 4'd1;
            K_BZ:    pc_d = Zero ? target : (pc_q + 4'd1);
            K_JMP:   pc_d = target;
            default: pc_d = pc_q;
          endcase
          // Watchdog: the step that reaches the limit ends the run as an abort.
          if (steps_inc == STEP_LIMIT) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath controls come straight from inst_q; wr is qualified by EXEC so an
  // asynchronous reset drops it immediately.
  assign wr         = (state_q == EXEC) && (kind == K_ALU);
  assign ALUControl = inst_q[11:9];
  assign addr1      = inst_q[8:7];
  assign addr2      = inst_q[6:5];
  assign addr3      = inst_q[1:0];
  assign busy       = (state_q == FETCH) || (state_q == EXEC);
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign dbg_state  = state_q;
  assign dbg_pc     = pc_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a small 8-bit Datapath model and
// an EXEC-cycle trace scoreboard.
module tb_datapath_sequencer;

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_EXEC = 2'd2;
  localparam logic [2:0]  OP_AND = 3'b000;
  localparam logic [2:0]  OP_OR  = 3'b001;
  localparam logic [2:0]  OP_ADD = 3'b010;
  localparam logic [2:0]  OP_SUB = 3'b110;
  localparam logic [13:0] HALT_W = 14'h3000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        load_en = 1'b0;
  logic [3:0]  load_addr = 4'd0;
  logic [13:0] load_data = 14'd0;
  logic        start = 1'b0;
  logic        Zero;
  logic        wr, busy, done, err;
  logic [2:0]  ALUControl;
  logic [1:0]  addr1, addr2, addr3, dbg_state;
  logic [3:0]  dbg_pc;

  datapath_sequencer #(.MAX_STEPS(10), .STEP_W(8)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .Zero(Zero), .wr(wr),
    .ALUControl(ALUControl), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state), .dbg_pc(dbg_pc)
  );

  // Datapath model: 4 x 8-bit registers, combinational ALU and Zero
  logic [7:0] regs [4];
  logic [7:0] init_vals [4];
  logic       dp_init = 1'b0;
  logic [7:0] dp_res;

  always_comb begin
    case (ALUControl)
      OP_AND:  dp_res = regs[addr1] & regs[addr2];
      OP_OR:   dp_res = regs[addr1] | regs[addr2];
      OP_ADD:  dp_res = regs[addr1] + regs[addr2];
      OP_SUB:  dp_res = regs[addr1] - regs[addr2];
      default: dp_res = 8'h00;
    endcase
  end
  assign Zero = (dp_res == 8'h00);

  always @(posedge clk) begin
    if (dp_init) begin
      for (int i = 0; i < 4; i++) regs[i] <= init_vals[i];
    end else if (wr) begin
      regs[addr3] <= dp_res;
    end
  end

  // scoreboard: one record per EXEC cycle {pc, ALUControl, addr1, addr2, addr3, wr}
  logic [13:0] exp_q [$];
  logic [13:0] obs_q [$];
  logic [13:0] prog [16];
  int          wr_cnt = 0;
  int          base = 0;
  int          wr_base = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(negedge clk) begin
    if (rst && dbg_state == S_EXEC) obs_q.push_back({dbg_pc, ALUControl, addr1, addr2, addr3, wr});
    if (wr) wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] mk_alu(input logic [2:0] op, input logic [1:0] a1,
                                         input logic [1:0] a2, input logic [1:0] a3);
    return {2'b00, op, a1, a2, 3'b000, a3};
  endfunction

  function automatic logic [13:0] mk_bz(input logic [2:0] op, input logic [1:0] a1,
                                        input logic [1:0] a2, input logic [3:0] tgt);
    return {2'b01, op, a1, a2, 1'b0, tgt};
  endfunction

  function automatic logic [13:0] mk_jmp(input logic [3:0] tgt);
    return {2'b10, 8'h00, tgt};
  endfunction

  // expected EXEC record for the instruction at address pc
  task automatic exp_add(input logic [3:0] pc);
    logic [13:0] w;
    w = prog[pc];
    exp_q.push_back({pc, w[11:9], w[8:7], w[6:5], w[1:0], w[13:12] == 2'b00});
  endtask

  // driver tasks
  task automatic load_word(input logic [3:0] a, input logic [13:0] w);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = w;
    prog[a] = w;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic set_regs(input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] r2, input logic [7:0] r3);
    @(negedge clk);
    init_vals[0] = r0; init_vals[1] = r1; init_vals[2] = r2; init_vals[3] = r3;
    dp_init = 1'b1;
    @(negedge clk);
    dp_init = 1'b0;
  endtask

  // Cycle 1 is the start cycle; returns the cycle index in which done is seen.
  task automatic run_prog(input bit inject, input bit ld, input logic [3:0] la,
                          input logic [13:0] lw, output int cyc, output logic err_early);
    @(negedge clk);
    base = obs_q.size();
    wr_base = wr_cnt;
    exp_q.delete();
    start = 1'b1;
    if (ld) begin
      load_en = 1'b1; load_addr = la; load_data = lw;
      prog[la] = lw;
    end
    cyc = 1;
    err_early = 1'bx;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      load_en = 1'b0;
      if (cyc == 2) err_early = err;
      if (done) break;
      if (inject && cyc == 4) begin
        start = 1'b1; load_en = 1'b1; load_addr = 4'd3; load_data = HALT_W;
      end
    end
    if (!done) check("run_done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic check_trace(input string tag);
    check({tag, "_len"}, obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < obs_q.size()) check(tag, obs_q[base + i], exp_q[i]);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_wr"}, {31'd0, wr}, 32'd0);
    check({tag, "_outs"}, {ALUControl, addr1, addr2, addr3, busy, done, err, dbg_state, dbg_pc}, 32'd0);
  endtask

  int   cyc;
  logic err_early;
  int   wait_cnt;

  initial begin
    for (int i = 0; i < 4; i++) init_vals[i] = 8'h00;
    for (int i = 0; i < 16; i++) prog[i] = 14'h0000;

    // reset values
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b1;

    // program 1: four ALU ops then HALT; start/load pulses while busy must be ignored
    load_word(4'd0, mk_alu(OP_SUB, 2'd1, 2'd1, 2'd1));
    load_word(4'd1, mk_alu(OP_ADD, 2'd2, 2'd1, 2'd0));
    load_word(4'd2, mk_alu(OP_SUB, 2'd1, 2'd3, 2'd2));
    load_word(4'd3, mk_alu(OP_ADD, 2'd0, 2'd3, 2'd3));
    load_word(4'd4, HALT_W);
    set_regs(8'h33, 8'h5A, 8'hFF, 8'h01);
    run_prog(1'b1, 1'b0, 4'd0, 14'd0, cyc, err_early);
    for (int p = 0; p < 5; p++) exp_add(4'(p));
    check_trace("p1_trace");
    check("p1_done_cycle", cyc, 12);
    check("p1_err", {31'd0, err}, 32'd0);
    check("p1_wr_pulses", wr_cnt - wr_base, 4);
    check("p1_regs", {regs[0], regs[1], regs[2], regs[3]}, 32'hFF00FF00);
    @(negedge clk);
    check("p1_idle_after", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // reset during the EXEC of the ALU op at address 1 (writes R0)
    set_regs(8'h33, 8'h5A, 8'hFF, 8'h01);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cnt = 0;
    while (!(dbg_state == S_EXEC && dbg_pc == 4'd1) && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("mid_exec_reached", {26'd0, dbg_state, dbg_pc}, {26'd0, S_EXEC, 4'd1});
    check("mid_wr_before", {31'd0, wr}, 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outs("mid_reset");
    @(posedge clk);
    #1;
    check("mid_r0_kept", {24'd0, regs[0]}, 32'h33);
    @(negedge clk);
    rst = 1'b1;
    set_regs(8'h33, 8'h5A, 8'hFF, 8'h01);
    run_prog(1'b0, 1'b0, 4'd0, 14'd0, cyc, err_early);
    for (int p = 0; p < 5; p++) exp_add(4'(p));
    check_trace("mem_kept_trace");
    check("mem_kept_regs", {regs[0], regs[1], regs[2], regs[3]}, 32'hFF00FF00);

    // BZ taken (0 -> 5) then not taken (5 -> 6)
    load_word(4'd0, mk_bz(OP_SUB, 2'd1, 2'd1, 4'd5));
    load_word(4'd1, HALT_W);
    load_word(4'd5, mk_bz(OP_SUB, 2'd3, 2'd1, 4'd9));
    load_word(4'd6, mk_alu(OP_OR, 2'd2, 2'd3, 2'd0));
    load_word(4'd7, HALT_W);
    load_word(4'd9, HALT_W);
    set_regs(8'h00, 8'h00, 8'h00, 8'h01);
    run_prog(1'b0, 1'b0, 4'd0, 14'd0, cyc, err_early);
    exp_add(4'd0); exp_add(4'd5); exp_add(4'd6); exp_add(4'd7);
    check_trace("bz_trace");
    check("bz_r0", {24'd0, regs[0]}, 32'h01);
    check("bz_done_cycle", cyc, 10);

    // PC wrap: 0 (BZ not taken) -> 1 (JMP 14) -> 14 -> 15 -> 0 (BZ taken) -> 2 (HALT)
    load_word(4'd0, mk_bz(OP_SUB, 2'd2, 2'd3, 4'd2));
    load_word(4'd1, mk_jmp(4'd14));
    load_word(4'd2, HALT_W);
    load_word(4'd14, mk_alu(OP_SUB, 2'd2, 2'd2, 2'd2));
    load_word(4'd15, mk_alu(OP_ADD, 2'd0, 2'd1, 2'd0));
    set_regs(8'h00, 8'h07, 8'h01, 8'h00);
    run_prog(1'b0, 1'b0, 4'd0, 14'd0, cyc, err_early);
    exp_add(4'd0); exp_add(4'd1); exp_add(4'd14); exp_add(4'd15); exp_add(4'd0); exp_add(4'd2);
    check_trace("wrap_trace");
    check("wrap_regs", {regs[0], regs[2]}, 32'h0700);
    check("wrap_done_cycle", cyc, 14);

    // watchdog: JMP 0 forever, aborts after 10 EXEC cycles
    load_word(4'd0, mk_jmp(4'd0));
    run_prog(1'b0, 1'b0, 4'd0, 14'd0, cyc, err_early);
    for (int k = 0; k < 10; k++) exp_add(4'd0);
    check_trace("wd_trace");
    check("wd_done_cycle", cyc, 22);
    check("wd_err", {31'd0, err}, 32'd1);
    check("wd_wr_pulses", wr_cnt - wr_base, 0);
    @(negedge clk);
    check("wd_idle_after", {28'd0, dbg_state, busy, done}, {28'd0, S_IDLE, 2'b00});
    check("wd_err_held", {31'd0, err}, 32'd1);

    // load_en together with start: HALT written to address 0 is the first fetch; err clears
    run_prog(1'b0, 1'b1, 4'd0, HALT_W, cyc, err_early);
    exp_add(4'd0);
    check_trace("ldstart_trace");
    check("ldstart_err_cleared", {31'd0, err_early}, 32'd0);
    check("ldstart_done_cycle", cyc, 4);
    check("ldstart_err_end", {31'd0, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
